// File: rtl/alpha_seq_pkg.sv
// Shared definitions for the alpha column sequencer: FSM state encoding
// and the default result-wait limit.
package alpha_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_RES,
        DONE
    } state_t;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/alpha_seq_watchdog.sv
// Result-wait watchdog: down-counter reloaded while disabled, expires on the
// TIMEOUT-th consecutive enabled cycle.
module alpha_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/alpha_col_sequencer.sv
// Reads A alpha columns from the buffer, streams them to the argmax datapath
// and latches the result. Optional result watchdog: ALPHA_SEQ_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start
// READ     | issuing A buffer reads, addresses 0..A-1
// DRAIN    | last (tlast) beat presented to the datapath
// WAIT_RES | waiting for x_initial_tvalid (or watchdog expiry)
// DONE     | result latched, done pulse
module alpha_col_sequencer
    import alpha_seq_pkg::*;
#(
    parameter int J         = 14,
    parameter int A         = 2,
    parameter int DATAWIDTH = 16,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    localparam int AWIDTH   = $clog2(A) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_ren,
    output logic [AWIDTH-1:0]       mem_raddr,
    input  logic [J*DATAWIDTH-1:0]  mem_rdata,
    output logic [J*DATAWIDTH-1:0]  alpha_u_col,
    output logic                    alpha_u_col_tvalid,
    output logic                    alpha_u_col_tlast,
    input  logic [J*AWIDTH-1:0]     x_initial,
    input  logic                    x_initial_tvalid,
    output logic [J*AWIDTH-1:0]     x_out,
    output logic                    timeout_err
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(A - 1);

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 mem_ren_q;
    logic                 tvalid_q;
    logic                 tlast_q;
    logic [AWIDTH-1:0]    addr_q;
    logic [J*AWIDTH-1:0]  x_out_q;
    logic                 wd_expire;

`ifdef ALPHA_SEQ_TIMEOUT_EN
    logic terr_q;

    alpha_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == WAIT_RES),
        .expire_o (wd_expire)
    );

    assign timeout_err = terr_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mem_ren_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            addr_q    <= '0;
            x_out_q   <= '0;
`ifdef ALPHA_SEQ_TIMEOUT_EN
            terr_q    <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            // Read data arrives one cycle after the read, so the beat flags
            // are the read strobe delayed by one stage.
            tvalid_q <= mem_ren_q;
            tlast_q  <= mem_ren_q && (addr_q == LAST_ADDR);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= READ;
                        busy_q    <= 1'b1;
                        mem_ren_q <= 1'b1;
                        addr_q    <= '0;
                    end
                end
                READ: begin
                    if (addr_q == LAST_ADDR) begin
                        mem_ren_q <= 1'b0;
                        state_q   <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    addr_q  <= '0;
                    state_q <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (x_initial_tvalid) begin
                        x_out_q <= x_initial;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (wd_expire) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef ALPHA_SEQ_TIMEOUT_EN
                        terr_q  <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_ren_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign mem_ren            = mem_ren_q;
    assign mem_raddr          = addr_q;
    assign alpha_u_col        = mem_rdata;
    assign alpha_u_col_tvalid = tvalid_q;
    assign alpha_u_col_tlast  = tlast_q;
    assign x_out              = x_out_q;

endmodule

// File: tb/tb_alpha_col_sequencer.sv
// Self-checking bench for alpha_col_sequencer: randomized frames against a
// buffer/datapath model, plus an A=1 instance for the single-beat corner.
module tb_alpha_col_sequencer;

    localparam int J  = 14;
    localparam int A  = 2;
    localparam int DW = 16;
    localparam int TO = 8;
    localparam int AW = $clog2(A) + 1;
    localparam int XW = J * AW;
    localparam int CW = J * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           busy, done, mem_ren, tvalid, tlast, timeout_err;
    logic [AW-1:0]  mem_raddr;
    logic [CW-1:0]  mem_rdata = '0;
    logic [CW-1:0]  alpha_u_col;
    logic [XW-1:0]  x_initial = '0;
    logic           x_tvalid = 1'b0;
    logic [XW-1:0]  x_out;

    // Single-beat instance (A=1, J=2, DATAWIDTH=8 -> AWIDTH=1)
    logic           start1 = 1'b0, x_tvalid1 = 1'b0;
    logic           busy1, done1, ren1, tv1, tl1, terr1;
    logic [0:0]     raddr1;
    logic [15:0]    rdata1 = '0, col1, mem1 = '0;
    logic [1:0]     xi1 = '0, xo1;

    logic [CW-1:0]  mem [A];
    logic [XW-1:0]  exp_xout = '0;
    logic           exp_terr = 1'b0;

    logic [CW-1:0]  beat_q [$];
    bit             last_q [$];
    int             addr_log [$];
    int             done_cnt = 0;
    int             b0, a0, d0;
    int             n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    alpha_col_sequencer #(.J(J), .A(A), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .mem_ren            (mem_ren),
        .mem_raddr          (mem_raddr),
        .mem_rdata          (mem_rdata),
        .alpha_u_col        (alpha_u_col),
        .alpha_u_col_tvalid (tvalid),
        .alpha_u_col_tlast  (tlast),
        .x_initial          (x_initial),
        .x_initial_tvalid   (x_tvalid),
        .x_out              (x_out),
        .timeout_err        (timeout_err)
    );

    alpha_col_sequencer #(.J(2), .A(1), .DATAWIDTH(8), .TIMEOUT(TO)) dut1 (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start1),
        .busy               (busy1),
        .done               (done1),
        .mem_ren            (ren1),
        .mem_raddr          (raddr1),
        .mem_rdata          (rdata1),
        .alpha_u_col        (col1),
        .alpha_u_col_tvalid (tv1),
        .alpha_u_col_tlast  (tl1),
        .x_initial          (xi1),
        .x_initial_tvalid   (x_tvalid1),
        .x_out              (xo1),
        .timeout_err        (terr1)
    );

    // Alpha buffer: one-cycle read latency
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
        if (ren1)    rdata1    <= mem1;
    end

    always @(negedge clk) begin
        if (tvalid) begin
            beat_q.push_back(alpha_u_col);
            last_q.push_back(tlast);
        end
        if (mem_ren) addr_log.push_back(int'(mem_raddr));
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached=1 expected=0");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b0 = beat_q.size();
        a0 = addr_log.size();
        d0 = done_cnt;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},   256'(busy), 256'(0));
        chk({tag, "_done"},   256'(done), 256'(0));
        chk({tag, "_ren"},    256'(mem_ren), 256'(0));
        chk({tag, "_raddr"},  256'(mem_raddr), 256'(0));
        chk({tag, "_tvalid"}, 256'(tvalid), 256'(0));
        chk({tag, "_tlast"},  256'(tlast), 256'(0));
        chk({tag, "_xout"},   256'(x_out), 256'(0));
        chk({tag, "_terr"},   256'(timeout_err), 256'(0));
    endtask

    task automatic fill_mem_random();
        for (int k = 0; k < A; k++)
            for (int w = 0; w < CW; w += 32)
                mem[k][w +: 32] = $urandom;
    endtask

    task automatic wait_tlast(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (tvalid && tlast) ok = 1'b1;
        end
    endtask

    task automatic run_frame(input int hold, input int lat, input bit respond,
                             input bit spur, input logic [XW-1:0] xval);
        bit ok;
        int n;
        snap();
        @(posedge clk); #1 start = 1'b1;
        fork
            begin
                repeat (hold) @(posedge clk);
                #1 start = 1'b0;
            end
            begin
                if (spur) begin
                    @(posedge clk); #1 x_initial = ~xval; x_tvalid = 1'b1;
                    @(posedge clk); #1 x_tvalid = 1'b0;
                end
            end
            begin
                wait_tlast(ok);
                chk("tlast_seen", 256'(ok), 256'(1));
                chk("xout_before_result", 256'(x_out), 256'(exp_xout));
                if (respond) begin
                    repeat (lat) @(posedge clk);
                    #1 x_initial = xval; x_tvalid = 1'b1;
                    @(posedge clk); #1 x_tvalid = 1'b0;
                    exp_xout = xval;
                    @(negedge clk);
                    chk("done_pulse", 256'(done), 256'(1));
                    chk("busy_in_done", 256'(busy), 256'(1));
                    @(negedge clk);
                    chk("done_width", 256'(done), 256'(0));
                    chk("busy_after_done", 256'(busy), 256'(0));
                end else begin
                    n = 0;
                    for (int i = 0; i < 30; i++) begin
                        @(negedge clk);
                        if (!busy) break;
                        n++;
                    end
`ifdef ALPHA_SEQ_TIMEOUT_EN
                    exp_terr = 1'b1;
                    chk("wait_res_cycles", 256'(n), 256'(TO));
`else
                    chk("wait_res_forever", 256'(n), 256'(30));
`endif
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("nbeats", 256'(beat_q.size() - b0), 256'(A));
        for (int i = 0; i < A && (b0 + i) < beat_q.size(); i++) begin
            chk("beat_data", 256'(beat_q[b0 + i]), 256'(mem[i]));
            chk("beat_last", 256'(last_q[b0 + i]), 256'(i == A - 1));
        end
        chk("nreads", 256'(addr_log.size() - a0), 256'(A));
        for (int i = 0; i < A && (a0 + i) < addr_log.size(); i++)
            chk("read_addr", 256'(addr_log[a0 + i]), 256'(i));
        chk("done_count", 256'(done_cnt - d0), 256'(respond ? 1 : 0));
        chk("xout", 256'(x_out), 256'(exp_xout));
        chk("timeout_err", 256'(timeout_err), 256'(exp_terr));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame
        for (int l = 0; l < J; l++) begin
            mem[0][l*DW +: DW] = 16'd5;
            mem[1][l*DW +: DW] = 16'd9;
        end
        run_frame(1, 3, 1'b1, 1'b0, XW'($urandom));

        // Result pulse while idle is ignored
        snap();
        @(posedge clk); #1 x_initial = ~exp_xout; x_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1 x_tvalid = 1'b0;
        @(negedge clk);
        chk("idle_spur_xout", 256'(x_out), 256'(exp_xout));
        chk("idle_spur_done", 256'(done_cnt - d0), 256'(0));
        chk("idle_spur_busy", 256'(busy), 256'(0));

        // Start held for 10 cycles, result lands so DONE sees start high
        fill_mem_random();
        run_frame(10, 5, 1'b1, 1'b0, XW'($urandom));

        for (int f = 0; f < 6; f++) begin
            fill_mem_random();
            run_frame(1, int'($urandom_range(1, 6)), 1'b1, f[0], XW'($urandom));
        end

        // Datapath never answers
        fill_mem_random();
        run_frame(1, 0, 1'b0, 1'b0, '0);
`ifdef ALPHA_SEQ_TIMEOUT_EN
        fill_mem_random();
        run_frame(1, 2, 1'b1, 1'b0, XW'($urandom));
`else
        rst_n = 1'b0;
        exp_xout = '0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
`endif

        // Reset in the middle of READ
        fill_mem_random();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_raddr", 256'(mem_raddr), 256'(1));
        rst_n = 1'b0;
        exp_xout = '0;
        exp_terr = 1'b0;
        #1 check_idle_outputs("mid_reset");
        snap();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_beats", 256'(beat_q.size() - b0), 256'(0));
        chk("post_reset_reads", 256'(addr_log.size() - a0), 256'(0));
        chk("post_reset_busy", 256'(busy), 256'(0));

        // Single-beat frame on the A=1 instance
        mem1 = 16'($urandom);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        chk("a1_ren", 256'(ren1), 256'(1));
        chk("a1_raddr", 256'(raddr1), 256'(0));
        @(negedge clk);
        chk("a1_tvalid", 256'(tv1), 256'(1));
        chk("a1_tlast", 256'(tl1), 256'(1));
        chk("a1_data", 256'(col1), 256'(mem1));
        @(posedge clk); #1 xi1 = 2'b10; x_tvalid1 = 1'b1;
        @(posedge clk); #1 x_tvalid1 = 1'b0;
        @(negedge clk);
        chk("a1_done", 256'(done1), 256'(1));
        chk("a1_xout", 256'(xo1), 256'(2'b10));
        @(negedge clk);
        chk("a1_busy_after", 256'(busy1), 256'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alpha_col_sequencer.md
ALPHA_COL_SEQUENCER -- requirements
Module: alpha_col_sequencer

Interface
REQ-001 Parameters SHALL be: J, default 14, number of parallel rows (lanes); A, default 2, stream beats per frame (candidate count); DATAWIDTH, default 16, alpha word width; TIMEOUT, default 64, result-wait limit in cycles.
REQ-002 Derived localparam AWIDTH SHALL be $clog2(A)+1 and SHALL be used for both index width and memory address width.
REQ-003 Ports, in order, SHALL be:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin one frame; sampled only in IDLE.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the result is latched.
- mem_ren, output, 1: alpha buffer read enable.
- mem_raddr, output, AWIDTH: alpha buffer read address.
- mem_rdata, input, J*DATAWIDTH: buffer read data, valid exactly one cycle after mem_ren.
- alpha_u_col, output, J*DATAWIDTH: column to the argmax datapath.
- alpha_u_col_tvalid, output, 1: column beat valid.
- alpha_u_col_tlast, output, 1: last beat of the frame.
- x_initial, input, J*AWIDTH: argmax result from the datapath.
- x_initial_tvalid, input, 1: result valid.
- x_out, output, J*AWIDTH: latched result.
- timeout_err, output, 1: sticky watchdog flag.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, READ, DRAIN, WAIT_RES, DONE.
REQ-005 In IDLE, start=1 SHALL move the FSM to READ on the next edge; start in any other state SHALL be ignored.
REQ-006 In READ, mem_ren SHALL be 1 for exactly A consecutive cycles, with mem_raddr = 0,1,…,A-1; after the cycle with address A-1, the FSM SHALL go to DRAIN.
REQ-007 alpha_u_col_tvalid SHALL equal mem_ren delayed by one register stage.
REQ-008 alpha_u_col SHALL equal mem_rdata whenever alpha_u_col_tvalid=1; its value is don't-care otherwise.
REQ-009 alpha_u_col_tlast SHALL be 1 only on the beat carrying address A-1; for A=1, the single beat SHALL carry both tvalid and tlast.
REQ-010 DRAIN SHALL last one cycle, the cycle in which the tlast beat is presented, then move to WAIT_RES.
REQ-011 In WAIT_RES, x_initial_tvalid=1 SHALL latch x_initial into x_out and move the FSM to DONE.
REQ-012 x_initial_tvalid in any state other than WAIT_RES SHALL be ignored, and x_out SHALL hold its value.
REQ-013 DONE SHALL last one cycle, with done=1, then return to IDLE.
REQ-014 A start presented in the DONE cycle SHALL be ignored; back-to-back frames therefore have at least one IDLE cycle between them.
REQ-015 x_out SHALL hold its value until the next successful latch.
REQ-016 The address counter SHALL be AWIDTH bits wide, SHALL reset to 0 on entry to READ, and SHALL never wrap within a frame.

Reset
REQ-017 When rst_n=0, all outputs SHALL be forced immediately, without waiting for a clock edge: FSM=IDLE, busy=0, done=0, mem_ren=0, mem_raddr=0, alpha_u_col_tvalid=0, alpha_u_col_tlast=0, x_out=0, timeout_err=0, and the address and watchdog counters=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame with no partial beats emitted after release.
REQ-019 After rst_n deassertion, a start is accepted no earlier than the first full cycle following it.

Configuration
REQ-020 With ALPHA_SEQ_TIMEOUT_EN defined, a counter SHALL count WAIT_RES cycles.
REQ-021 With ALPHA_SEQ_TIMEOUT_EN defined, reaching TIMEOUT cycles in WAIT_RES without x_initial_tvalid SHALL set timeout_err=1 (sticky until reset) and return the FSM to IDLE with no done pulse and x_out unchanged.
REQ-022 With ALPHA_SEQ_TIMEOUT_EN undefined, WAIT_RES SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no watchdog counter SHALL be synthesized.

Structure
REQ-023 A shared package alpha_seq_pkg SHALL hold the FSM state enum (IDLE, READ, DRAIN, WAIT_RES, DONE) and the default TIMEOUT constant.
REQ-024 One sub-module, alpha_seq_watchdog (counter plus compare), SHALL be instantiated only under ALPHA_SEQ_TIMEOUT_EN; all other logic SHALL be flat.

Verification
REQ-025 Nominal frame: A=2, J=14, buffer word0 = lanes all 5, word1 = lanes all 9; start pulse, datapath model returns x_initial after 3 cycles -> exactly two beats, tlast on the second, alpha_u_col matching each word, x_out = datapath value, done high for 1 cycle, busy low the cycle after done.
REQ-026 Start while busy: start held high for 10 cycles -> exactly A beats and one done pulse.
REQ-027 Spurious result: x_initial_tvalid pulsed in IDLE and in READ -> x_out unchanged, no done pulse.
REQ-028 Mid-frame reset: rst_n pulled low during READ address 1 -> all outputs 0 immediately; no beat after release until a new start.
REQ-029 Timeout, macro defined, TIMEOUT=8: datapath never responds -> after 8 WAIT_RES cycles timeout_err=1, FSM in IDLE, no done pulse; the next frame completes normally with timeout_err still 1.
REQ-030 A=1 corner: a single beat carries tvalid=1 and tlast=1 together, mem_raddr=0, and the frame completes.
